irq_ctrl: RTL and testbench
===========================

// Module: irq_ctrl
// PURPOSE
//  Parametrised interrupt controller between the peripheral interrupt lines (sctrl, dma[1:0], epu, ...)
//  and the CPU interrupt input. Replaces the fixed concatenated interrupt bus with per-source
//  enable, level/edge mode, programmable priority, threshold and claim/complete handshake.
//  Register port is driven by the slave-wrapper side of the AXI fabric; irq_o/irq_id_o feed CPU_wrapper.
// PARAMETERS
//  NUM_SRC      4   number of interrupt sources (1..8); NUM_SRC*PRIO_BITS must be <= 32
//  PRIO_BITS    3   priority field width per source; priority 0 = never interrupts
//  SYNC_STAGES  2   input synchroniser depth per source; 0 = sources already in clk domain
// PORTS
//  clk        in   1            system clock
//  rst        in   1            asynchronous, active-low reset
//  src_i      in   NUM_SRC      raw interrupt lines, bit n = source n
//  reg_en     in   1            register access strobe, one cycle per access
//  reg_we     in   1            1 = write, 0 = read
//  reg_addr   in   3            word index (byte addr[4:2])
//  reg_wdata  in   32           write data
//  reg_rdata  out  32           read data, valid the cycle after a read strobe
//  irq_o      out  1            level interrupt request to the CPU
//  irq_id_o   out  4            current winner id+1 (0 = none), registered
// BEHAVIOUR
//  Reset: all registers, pending, in-service, sync/edge flops, reg_rdata, irq_o, irq_id_o = 0.
//  Register map (reg_addr): 0 PENDING (R; W1C, affects edge-mode bits only), 1 ENABLE (RW),
//   2 MODE (RW, 1 = rising-edge, 0 = level), 3 THRESHOLD (RW, [PRIO_BITS-1:0]),
//   4 CLAIM (R = claim) / COMPLETE (W, wdata[3:0] = id+1), 5 PRIO (RW, source n at [n*PRIO_BITS +: PRIO_BITS]).
//   Unused bits read 0, writes ignored; reg_addr 6-7 read 0, writes ignored.
//  Input path: src_i -> SYNC_STAGES flops -> s[n]. Edge flop prev[n] resets to 0, so a line high at
//   reset release counts as one rising edge.
//  Pending: edge mode: set on s & ~prev; cleared by a claim of that source or W1C. If set and clear coincide, set wins.
//   Level mode: pending[n] = s[n] (combinational from the synced level, no latch). Switching MODE clears pending[n].
//  In-service: set[n] on claim of n; cleared by COMPLETE carrying n+1. COMPLETE with an id not in service,
//   or with 0, or with id > NUM_SRC is ignored.
//  Eligible[n] = pending & enable & ~in_service & (prio[n] > threshold). prio 0 is never eligible.
//  Arbitration (combinational): highest prio among eligible; ties go to lowest index; winner id = n+1, 0 if none.
//  irq_o/irq_id_o register (eligible != 0)/winner: latency is 1 clk from an eligible change
//   (SYNC_STAGES+1 clk from src_i for a level-mode source).
//  Read: reg_rdata updates on the clk edge after reg_en & ~reg_we and holds until the next read.
//   CLAIM read returns the winner at the strobe cycle, sets its in_service and clears its edge pending
//   in that same edge. A winner of 0 returns 0 with no state change.
//  Write: takes effect on the strobe edge. Register writes and src events on the same edge are applied
//   together, with the set-wins rule above.
//  Level-mode source still high after COMPLETE re-pends immediately. The bench must see irq_o re-assert 1 clk after COMPLETE.
//  Asserting rst mid-operation clears everything asynchronously. No pending or in-service state survives reset.
// TESTING
//  1 Reset: hold rst=0 with src_i toggling -> irq_o=0, reg_rdata=0; every register reads 0 after release.
//  2 Edge: MODE=4'hF, ENABLE=4'hF, PRIO src1=3, pulse src_i[1] one clk -> PENDING=4'h2, irq_o=1, irq_id_o=2;
//    CLAIM reads 2 and PENDING then reads 0; irq_o=0; COMPLETE 2 -> in-service cleared.
//  3 Priority/tie: src0 prio 2, src2 prio 5, src3 prio 5, all pending -> CLAIM returns 3, then 4, then 1.
//  4 Threshold: THRESHOLD=4, src0 prio 4 pending -> irq_o stays 0; THRESHOLD=3 -> irq_o=1 next clk.
//  5 Level re-pend: MODE=0, src_i[0] held high, claim (reads 1), COMPLETE 1 -> irq_o re-asserts 1 clk later;
//    src_i[0] low -> irq_o=0 SYNC_STAGES+1 clks later.
//  6 Corners: edge arrives in the same cycle as its claim -> PENDING bit still 1; COMPLETE 7 (id > NUM_SRC)
//    -> no change; CLAIM with nothing eligible -> reads 0.

Source files
------------

// File: rtl/irq_ctrl.sv
// Parametrised interrupt controller: per-source sync, level/edge pending, enable, priority,
// threshold and claim/complete in-service tracking, with a small word-addressed register port.
module irq_ctrl #(
    parameter int NUM_SRC     = 4,
    parameter int PRIO_BITS   = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_SRC-1:0]   src_i,
    input  logic                 reg_en,
    input  logic                 reg_we,
    input  logic [2:0]           reg_addr,
    input  logic [31:0]          reg_wdata,
    output logic [31:0]          reg_rdata,
    output logic                 irq_o,
    output logic [3:0]           irq_id_o
);

    localparam int PW = NUM_SRC * PRIO_BITS;

    localparam logic [2:0] A_PENDING = 3'd0;
    localparam logic [2:0] A_ENABLE  = 3'd1;
    localparam logic [2:0] A_MODE    = 3'd2;
    localparam logic [2:0] A_THRESH  = 3'd3;
    localparam logic [2:0] A_CLAIM   = 3'd4;
    localparam logic [2:0] A_PRIO    = 3'd5;

    logic [NUM_SRC-1:0]   s;
    logic [NUM_SRC-1:0]   prev;
    logic [NUM_SRC-1:0]   enable;
    logic [NUM_SRC-1:0]   mode;
    logic [PRIO_BITS-1:0] thresh;
    logic [PW-1:0]        prio;
    logic [NUM_SRC-1:0]   pend_edge;
    logic [NUM_SRC-1:0]   in_svc;

    logic [NUM_SRC-1:0]   pending;
    logic [NUM_SRC-1:0]   eligible;
    logic [3:0]           winner;
    logic [NUM_SRC-1:0]   claim_oh;
    logic [NUM_SRC-1:0]   cmpl_oh;
    logic [NUM_SRC-1:0]   mode_nxt;
    logic [NUM_SRC-1:0]   pend_clr;
    logic [31:0]          rdata_mux;
    logic                 rd_stb;
    logic                 wr_stb;
    logic                 unused_wdata;

    assign unused_wdata = ^reg_wdata;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = src_i;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0][NUM_SRC-1:0] sync_q;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= src_i;
                    for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
                end
            end
            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    assign rd_stb = reg_en & ~reg_we;
    assign wr_stb = reg_en & reg_we;

    // Edge pending is only kept for edge-mode bits; level bits follow the synced line directly.
    assign pending = (pend_edge & mode) | (s & ~mode);

    always_comb begin
        eligible = '0;
        for (int n = 0; n < NUM_SRC; n++)
            eligible[n] = pending[n] & enable[n] & ~in_svc[n] &
                          (prio[n*PRIO_BITS +: PRIO_BITS] > thresh);
    end

    // Strict compare while scanning upward keeps ties on the lowest index.
    always_comb begin
        logic [PRIO_BITS-1:0] best;
        best   = '0;
        winner = '0;
        for (int n = 0; n < NUM_SRC; n++) begin
            if (eligible[n] && (prio[n*PRIO_BITS +: PRIO_BITS] > best)) begin
                best   = prio[n*PRIO_BITS +: PRIO_BITS];
                winner = 4'(n + 1);
            end
        end
    end

    always_comb begin
        claim_oh = '0;
        cmpl_oh  = '0;
        for (int n = 0; n < NUM_SRC; n++) begin
            claim_oh[n] = rd_stb && (reg_addr == A_CLAIM) && (winner == 4'(n + 1));
            cmpl_oh[n]  = wr_stb && (reg_addr == A_CLAIM) && (reg_wdata[3:0] == 4'(n + 1));
        end
    end

    assign mode_nxt = (wr_stb && reg_addr == A_MODE) ? reg_wdata[NUM_SRC-1:0] : mode;
    assign pend_clr = claim_oh | (mode ^ mode_nxt) |
                      ((wr_stb && reg_addr == A_PENDING) ? reg_wdata[NUM_SRC-1:0] : '0);

    always_comb begin
        rdata_mux = '0;
        case (reg_addr)
            A_PENDING: rdata_mux = 32'(pending);
            A_ENABLE:  rdata_mux = 32'(enable);
            A_MODE:    rdata_mux = 32'(mode);
            A_THRESH:  rdata_mux = 32'(thresh);
            A_CLAIM:   rdata_mux = 32'(winner);
            A_PRIO:    rdata_mux = 32'(prio);
            default:   rdata_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev      <= '0;
            enable    <= '0;
            mode      <= '0;
            thresh    <= '0;
            prio      <= '0;
            pend_edge <= '0;
            in_svc    <= '0;
            reg_rdata <= '0;
            irq_o     <= 1'b0;
            irq_id_o  <= '0;
        end else begin
            prev      <= s;
            mode      <= mode_nxt;
            pend_edge <= ((pend_edge & ~pend_clr) | (s & ~prev)) & mode_nxt;
            in_svc    <= (in_svc | claim_oh) & ~cmpl_oh;
            irq_o     <= |eligible;
            irq_id_o  <= winner;
            if (rd_stb) reg_rdata <= rdata_mux;
            if (wr_stb && reg_addr == A_ENABLE) enable <= reg_wdata[NUM_SRC-1:0];
            if (wr_stb && reg_addr == A_THRESH) thresh <= reg_wdata[PRIO_BITS-1:0];
            if (wr_stb && reg_addr == A_PRIO)   prio   <= reg_wdata[PW-1:0];
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios plus random traffic, every cycle compared against
// a behavioural model built from the register-level rules.
module tb_irq_ctrl;

    localparam int NS = 4;
    localparam int PB = 3;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NS-1:0] src_i = '0;
    logic          reg_en = 1'b0;
    logic          reg_we = 1'b0;
    logic [2:0]    reg_addr = '0;
    logic [31:0]   reg_wdata = '0;
    logic [31:0]   reg_rdata;
    logic          irq_o;
    logic [3:0]    irq_id_o;

    int checks = 0;
    int errors = 0;

    irq_ctrl #(.NUM_SRC(NS), .PRIO_BITS(PB), .SYNC_STAGES(SS)) dut (
        .clk       (clk),
        .rst       (rst),
        .src_i     (src_i),
        .reg_en    (reg_en),
        .reg_we    (reg_we),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .irq_o     (irq_o),
        .irq_id_o  (irq_id_o)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [NS-1:0] shist[$];
    logic [NS-1:0] m_prev, m_en, m_mode, m_pe, m_isv;
    int            m_thr;
    int            m_prio[NS];
    logic [31:0]   m_rdata;
    logic          m_irq;
    logic [3:0]    m_id;

    function automatic logic [NS-1:0] m_s();
        return (SS == 0) ? src_i : shist[0];
    endfunction

    function automatic logic [NS-1:0] m_pending();
        logic [NS-1:0] s = m_s();
        logic [NS-1:0] p;
        for (int n = 0; n < NS; n++) p[n] = m_mode[n] ? m_pe[n] : s[n];
        return p;
    endfunction

    function automatic logic [NS-1:0] m_elig();
        logic [NS-1:0] p = m_pending();
        logic [NS-1:0] e;
        for (int n = 0; n < NS; n++)
            e[n] = p[n] && m_en[n] && !m_isv[n] && (m_prio[n] > m_thr);
        return e;
    endfunction

    function automatic logic [3:0] m_winner();
        logic [NS-1:0] e = m_elig();
        for (int p = (1 << PB) - 1; p >= 1; p--)
            for (int n = 0; n < NS; n++)
                if (e[n] && m_prio[n] == p) return 4'(n + 1);
        return 4'd0;
    endfunction

    task automatic m_reset();
        shist.delete();
        for (int i = 0; i < SS; i++) shist.push_back('0);
        m_prev = '0; m_en = '0; m_mode = '0; m_pe = '0; m_isv = '0;
        m_thr = 0; m_rdata = '0; m_irq = 1'b0; m_id = '0;
        for (int n = 0; n < NS; n++) m_prio[n] = 0;
    endtask

    task automatic m_edge();
        logic [NS-1:0] s    = m_s();
        logic [NS-1:0] pend = m_pending();
        logic [NS-1:0] el   = m_elig();
        logic [3:0]    win  = m_winner();
        logic          rd   = reg_en && !reg_we;
        logic          wr   = reg_en && reg_we;
        logic [NS-1:0] new_mode = (wr && reg_addr == 3'd2) ? reg_wdata[NS-1:0] : m_mode;
        logic [NS-1:0] new_pe;
        logic [31:0]   pk = '0;
        int            id;
        for (int n = 0; n < NS; n++) begin
            logic clr;
            clr = (rd && reg_addr == 3'd4 && win == 4'(n + 1)) ||
                  (wr && reg_addr == 3'd0 && reg_wdata[n]) ||
                  (new_mode[n] != m_mode[n]);
            new_pe[n] = (m_pe[n] && !clr) || (s[n] && !m_prev[n]);
            new_pe[n] = new_pe[n] && new_mode[n];
        end
        for (int n = 0; n < NS; n++) pk = pk | (32'(m_prio[n]) << (n * PB));
        if (rd) begin
            case (reg_addr)
                3'd0: m_rdata = 32'(pend);
                3'd1: m_rdata = 32'(m_en);
                3'd2: m_rdata = 32'(m_mode);
                3'd3: m_rdata = 32'(m_thr);
                3'd4: m_rdata = 32'(win);
                3'd5: m_rdata = pk;
                default: m_rdata = '0;
            endcase
            if (reg_addr == 3'd4 && win != 0) m_isv[win - 1] = 1'b1;
        end
        if (wr) begin
            case (reg_addr)
                3'd1: m_en = reg_wdata[NS-1:0];
                3'd3: m_thr = int'(reg_wdata[PB-1:0]);
                3'd4: begin
                    id = int'(reg_wdata[3:0]);
                    if (id >= 1 && id <= NS) m_isv[id - 1] = 1'b0;
                end
                3'd5: for (int n = 0; n < NS; n++) m_prio[n] = int'((reg_wdata >> (n * PB)) & ((1 << PB) - 1));
                default: ;
            endcase
        end
        m_mode = new_mode;
        m_pe   = new_pe;
        m_irq  = (el != 0);
        m_id   = win;
        m_prev = s;
        shist.push_back(src_i);
        void'(shist.pop_front());
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rst) m_edge(); else m_reset();
        #1;
        chk("irq_o", 32'(irq_o), 32'(m_irq));
        chk("irq_id_o", 32'(irq_id_o), 32'(m_id));
        chk("reg_rdata", reg_rdata, m_rdata);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        reg_en = 1'b1; reg_we = 1'b1; reg_addr = a; reg_wdata = d;
        cyc();
        reg_en = 1'b0; reg_we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        reg_en = 1'b1; reg_we = 1'b0; reg_addr = a;
        cyc();
        reg_en = 1'b0;
        d = reg_rdata;
    endtask

    task automatic pulse(input logic [NS-1:0] m);
        src_i = m;
        cyc();
        src_i = '0;
    endtask

    task automatic async_reset();
        #2 rst = 1'b0;
        m_reset();
        #1;
        chk("async_rst_irq", 32'(irq_o), 32'd0);
        chk("async_rst_id", 32'(irq_id_o), 32'd0);
        chk("async_rst_rdata", reg_rdata, 32'd0);
        for (int i = 0; i < 3; i++) begin
            src_i = NS'($urandom);
            cyc();
        end
        src_i = '0;
        #2 rst = 1'b1;
        idle(3);
    endtask

    logic [31:0] d;

    initial begin
        m_reset();

        // 1: reset held with toggling inputs
        for (int i = 0; i < 6; i++) begin
            src_i = NS'($urandom);
            cyc();
            chk("rst_irq", 32'(irq_o), 32'd0);
            chk("rst_rdata", reg_rdata, 32'd0);
        end
        src_i = '0;
        #2 rst = 1'b1;
        idle(3);
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), d);
            chk("rst_reg", d, 32'd0);
        end

        // 2: edge source, claim, complete
        wr(3'd2, 32'hF);
        wr(3'd1, 32'hF);
        wr(3'd5, 32'h18);
        pulse(4'b0010);
        idle(3);
        chk("edge_irq", 32'(irq_o), 32'd1);
        chk("edge_id", 32'(irq_id_o), 32'd2);
        rd(3'd0, d); chk("edge_pending", d, 32'h2);
        rd(3'd4, d); chk("edge_claim", d, 32'd2);
        rd(3'd0, d); chk("edge_pending_clr", d, 32'h0);
        chk("edge_irq_drop", 32'(irq_o), 32'd0);
        wr(3'd4, 32'd2);
        pulse(4'b0010);
        idle(3);
        chk("edge_after_complete", 32'(irq_o), 32'd1);
        rd(3'd4, d); chk("edge_claim2", d, 32'd2);
        wr(3'd4, 32'd2);

        // 3: priority and tie-break
        wr(3'd5, 32'hB42);
        pulse(4'b1101);
        idle(3);
        rd(3'd4, d); chk("prio_claim_a", d, 32'd3);
        rd(3'd4, d); chk("prio_claim_b", d, 32'd4);
        rd(3'd4, d); chk("prio_claim_c", d, 32'd1);
        wr(3'd4, 32'd1); wr(3'd4, 32'd3); wr(3'd4, 32'd4);

        // 4: threshold
        wr(3'd5, 32'd4);
        wr(3'd3, 32'd4);
        pulse(4'b0001);
        idle(4);
        chk("thr_block", 32'(irq_o), 32'd0);
        wr(3'd3, 32'd3);
        chk("thr_lat0", 32'(irq_o), 32'd0);
        cyc();
        chk("thr_pass", 32'(irq_o), 32'd1);
        rd(3'd4, d); chk("thr_claim", d, 32'd1);
        wr(3'd4, 32'd1);
        wr(3'd3, 32'd0);

        // 5: level re-pend
        wr(3'd2, 32'd0);
        src_i = 4'b0001;
        idle(SS + 1);
        chk("lvl_irq", 32'(irq_o), 32'd1);
        rd(3'd4, d); chk("lvl_claim", d, 32'd1);
        wr(3'd4, 32'd1);
        chk("lvl_complete_edge", 32'(irq_o), 32'd0);
        cyc();
        chk("lvl_repend", 32'(irq_o), 32'd1);
        src_i = '0;
        idle(SS);
        chk("lvl_fall_hold", 32'(irq_o), 32'd1);
        cyc();
        chk("lvl_fall", 32'(irq_o), 32'd0);

        // 6: corners
        wr(3'd2, 32'hF);
        wr(3'd5, 32'h18);
        pulse(4'b0010);
        idle(3);
        chk("corner_irq", 32'(irq_o), 32'd1);
        src_i = 4'b0010; cyc();
        src_i = '0;      cyc();
        rd(3'd4, d); chk("corner_claim", d, 32'd2);
        rd(3'd0, d); chk("corner_setwins", d, 32'h2);
        wr(3'd4, 32'd7);
        rd(3'd0, d); chk("corner_bad_id_pend", d, 32'h2);
        chk("corner_bad_id_irq", 32'(irq_o), 32'd0);
        rd(3'd4, d); chk("corner_empty_claim", d, 32'd0);
        wr(3'd4, 32'd2);
        cyc();
        chk("corner_reassert", 32'(irq_o), 32'd1);
        rd(3'd4, d); chk("corner_claim2", d, 32'd2);
        wr(3'd4, 32'd2);

        // mid-operation asynchronous reset
        wr(3'd5, 32'hFFF);
        pulse(4'hF);
        idle(3);
        rd(3'd4, d);
        async_reset();
        for (int a = 0; a < 6; a++) begin
            rd(3'(a), d);
            chk("post_rst_reg", d, 32'd0);
        end

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) == 0) src_i = NS'($urandom);
            case ($urandom_range(5))
                0: cyc();
                1: wr(3'($urandom_range(7)), $urandom);
                2: wr(3'd4, 32'($urandom_range(8)));
                3: wr(3'd3, 32'($urandom_range(7)));
                4: rd(3'($urandom_range(7)), d);
                default: rd(3'd4, d);
            endcase
            if (i == 200) async_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
